// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-sequence controller: FSM state encoding,
// default parameter values and a small elaboration helper.
package shift_seq_pkg;

    // Sequence phases; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    // Default configuration: 10-bit register, 5M-cycle tick, 4-tick hold,
    // 250k-cycle debounce window.
    localparam int unsigned DEF_WIDTH      = 10;
    localparam int unsigned DEF_TICK_DIV   = 5000000;
    localparam int unsigned DEF_HOLD_TICKS = 4;
    localparam int unsigned DEF_DB_CYCLES  = 250000;

    // Larger of two unsigned values, used to size shared counters.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Bundle between the controller and its environment: the raw button request
// in, the shift strobe/data and status out.
//
// Strobe semantics: shift_en is a single-cycle strobe. The downstream
// register shifts left once on every rising clkin edge at which shift_en=1
// and loads ser_in into bit 0; ser_in only carries meaning while shift_en=1.
// There is no back-pressure: downstream must accept every strobe.
interface shift_seq_ctrl_if #(
    parameter int unsigned WIDTH = shift_seq_pkg::DEF_WIDTH
);
    localparam int unsigned FW = $clog2(WIDTH + 1);

    logic          button;
    logic          shift_en;
    logic          ser_in;
    logic [1:0]    state;
    logic          busy;
    logic [FW-1:0] fill_level;

    // Environment side: drives the request, observes strobes and status.
    modport master (
        output button,
        input  shift_en,
        input  ser_in,
        input  state,
        input  busy,
        input  fill_level
    );

    // Controller side.
    modport slave (
        input  button,
        output shift_en,
        output ser_in,
        output state,
        output busy,
        output fill_level
    );
endinterface

// File: rtl/shift_seq_ctrl_btn_cond.sv
// Button conditioning for the shift-sequence controller: two-flop
// synchroniser, optional debounce, and rising-edge detection into a
// one-cycle press pulse.
// Build option: define SHIFT_SEQ_DEBOUNCE_EN to insert the debouncer;
// without it the press is taken straight from the synchroniser output.
module btn_cond
    import shift_seq_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic i_button,
    output logic o_press
);

    logic [1:0] r_sync;
    logic [1:0] r_valid;
    logic       r_armed;
    logic       r_prev;
    logic       w_level;

    // Two-flop synchroniser; r_valid marks when r_sync[1] first reflects a
    // post-reset sample of the pin.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_valid <= 2'b00;
        end else begin
            r_sync  <= {r_sync[0], i_button};
            r_valid <= {r_valid[0], 1'b1};
        end
    end

`ifdef SHIFT_SEQ_DEBOUNCE_EN
    localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [DBW-1:0] r_db_cnt;
    logic           r_db_level;

    // Debouncer: a new level is accepted only after DB_CYCLES consecutive
    // synchronised samples that disagree with the current accepted level.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (r_sync[1] != r_db_level) begin
            if (r_db_cnt == DBW'(DB_CYCLES - 1)) begin
                r_db_level <= r_sync[1];
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync[1];

    // DB_CYCLES only shapes the debouncer; it is still referenced here so
    // both builds accept the same parameter set.
    if (DB_CYCLES == 0) begin : g_db_cycles_zero
    end
`endif

    // Arm edge detection only once a genuine low has been seen after reset,
    // so a button held through reset release never counts as a press.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else if (r_valid[1] && !r_sync[1]) begin
            r_armed <= 1'b1;
        end
    end

    // Previous conditioned level for rising-edge detection.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_press = w_level & ~r_prev & r_armed;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift-sequence controller: fills a downstream shift register with ones at
// one bit per prescaler tick, holds it full, then drains it with zeros.
// A button press starts a sequence from IDLE or aborts FILL/HOLD into DRAIN.
// Build option: SHIFT_SEQ_DEBOUNCE_EN enables button debounce in btn_cond.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned HOLD_TICKS = DEF_HOLD_TICKS,
    parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    shift_seq_ctrl_if.slave      bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = $clog2(max_u(WIDTH, HOLD_TICKS) + 1);
    localparam int unsigned FW = $clog2(WIDTH + 1);

    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          w_press;

    seq_state_e    r_state;
    seq_state_e    w_state_nxt;
    logic [SW-1:0] r_step;
    logic [SW-1:0] w_step_nxt;
    logic [FW-1:0] r_fill;
    logic [FW-1:0] w_fill_nxt;
    logic          r_shift_en;
    logic          w_shift_en_nxt;
    logic          r_ser_in;
    logic          w_ser_in_nxt;

    btn_cond #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_cond (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .i_button (bus.button),
        .o_press  (w_press)
    );

    // Free-running prescaler; the tick is the single cycle at its top count.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    // FSM state, step counter, fill level and the registered strobe/data.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_step     <= '0;
            r_fill     <= '0;
            r_shift_en <= 1'b0;
            r_ser_in   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_fill     <= w_fill_nxt;
            r_shift_en <= w_shift_en_nxt;
            r_ser_in   <= w_ser_in_nxt;
        end
    end

    // Next-state logic. A press always takes priority over a coincident
    // tick, so an abort never emits a strobe in the cycle it is taken.
    // The step counter counts shifts in FILL/DRAIN and ticks in HOLD.
    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_fill_nxt     = r_fill;
        w_shift_en_nxt = 1'b0;
        w_ser_in_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_state_nxt = FILL;
                    w_step_nxt  = '0;
                end
            end

            FILL: begin
                if (w_press) begin
                    w_state_nxt = DRAIN;
                    w_step_nxt  = '0;
                end else if (w_tick) begin
                    w_shift_en_nxt = 1'b1;
                    w_ser_in_nxt   = 1'b1;
                    if (r_fill != FW'(WIDTH)) begin
                        w_fill_nxt = r_fill + 1'b1;
                    end
                    if (r_step == SW'(WIDTH - 1)) begin
                        w_state_nxt = HOLD;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
            end

            HOLD: begin
                if (w_press) begin
                    w_state_nxt = DRAIN;
                    w_step_nxt  = '0;
                end else if (w_tick) begin
                    if (r_step == SW'(HOLD_TICKS - 1)) begin
                        w_state_nxt = DRAIN;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
            end

            DRAIN: begin
                // Presses are ignored here: DRAIN always runs all WIDTH shifts
                // so the downstream register ends up fully cleared.
                if (w_tick) begin
                    w_shift_en_nxt = 1'b1;
                    w_ser_in_nxt   = 1'b0;
                    if (r_fill != '0) begin
                        w_fill_nxt = r_fill - 1'b1;
                    end
                    if (r_step == SW'(WIDTH - 1)) begin
                        w_state_nxt = IDLE;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
        endcase
    end

    assign bus.shift_en   = r_shift_en;
    assign bus.ser_in     = r_ser_in;
    assign bus.state      = r_state;
    assign bus.busy       = (r_state != IDLE);
    assign bus.fill_level = r_fill;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl (TICK_DIV=4, WIDTH=10,
// HOLD_TICKS=2, DB_CYCLES=3). Expected strobes are queued when a sequence is
// started and compared as the DUT emits them.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int unsigned WIDTH      = 10;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned HOLD_TICKS = 2;
  localparam int unsigned DB_CYCLES  = 3;
  localparam int FW = $clog2(WIDTH + 1);
  localparam int EW = 1 + FW + 8;

`ifdef SHIFT_SEQ_DEBOUNCE_EN
  localparam int LEAD      = 1;
  localparam int PRESS_LAT = 5;
  localparam int RAISE_DLY = 2;
`else
  localparam int LEAD      = 0;
  localparam int PRESS_LAT = 2;
  localparam int RAISE_DLY = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  always #5 clkin = ~clkin;

  shift_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  shift_seq_ctrl #(
    .WIDTH      (WIDTH),
    .TICK_DIV   (TICK_DIV),
    .HOLD_TICKS (HOLD_TICKS),
    .DB_CYCLES  (DB_CYCLES)
  ) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  // entry = {ser_in, fill_level, gap}; gap 0 means spacing is not checked
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_strobe = 0;
  int n_ones = 0;
  int n_zeros = 0;
  int btn_left = 0;

  typedef struct {
    string name;
    int    abort_at;   // fill strobe count at which to abort, 0 = none
    int    drain_at;   // drain strobe count at which to press, 0 = none
    int    exp_ones;
    int    exp_zeros;
    int    first_gap;  // cycles from last fill strobe to first drain strobe
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input bit s, input int f, input int g);
    return {s, FW'(f), 8'(g)};
  endfunction

  // queue the strobes of one sequence: n_fill ones, then WIDTH zeros
  task automatic push_run(input int n_fill, input int first_gap);
    for (int k = 1; k <= n_fill; k++)
      exp_q.push_back(mk(1'b1, k, (k == 1) ? 0 : TICK_DIV));
    for (int j = 1; j <= WIDTH; j++)
      exp_q.push_back(mk(1'b0, (n_fill > j) ? n_fill - j : 0,
                         (j == 1) ? first_gap : TICK_DIV));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clkin) begin
    cyc++;
    if (rst_n && bus.shift_en) begin
      if (bus.ser_in) n_ones++;
      else n_zeros++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got shift_en=1 ser_in=%0d fill=%0d expected no strobe",
                 bus.ser_in, bus.fill_level);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_ser_in", int'(bus.ser_in), int'(mon_e[EW-1]));
        check("strobe_fill_level", int'(bus.fill_level), int'(mon_e[EW-2 -: FW]));
        if (mon_e[7:0] != 8'd0)
          check("strobe_gap", cyc - last_strobe, int'(mon_e[7:0]));
      end
      last_strobe = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_cycle();
    @(negedge clkin);
    #1;
    if (btn_left > 0) begin
      btn_left--;
      if (btn_left == 0) bus.button = 1'b0;
    end
  endtask

  task automatic pulse(input int len);
    bus.button = 1'b1;
    btn_left = len;
  endtask

  task automatic wait_ones(input string name, input int n);
    int c;
    c = 0;
    while (n_ones < n && c < 300) begin
      step_cycle();
      c++;
    end
    if (n_ones < n) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d fill strobes expected %0d", name, n_ones, n);
    end
  endtask

  task automatic finish_run(input string name, input int exp_ones, input int exp_zeros);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || btn_left != 0) && c < 800) begin
      step_cycle();
      c++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d strobes outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (8) step_cycle();
    check($sformatf("%s_ones", name), n_ones, exp_ones);
    check($sformatf("%s_zeros", name), n_zeros, exp_zeros);
    check($sformatf("%s_state", name), int'(bus.state), int'(IDLE));
    check($sformatf("%s_busy", name), int'(bus.busy), 0);
    check($sformatf("%s_fill", name), int'(bus.fill_level), 0);
  endtask

  task automatic run_vec(input vec_t v);
    bit abort_done, drain_done;
    int c;
    n_ones = 0;
    n_zeros = 0;
    abort_done = (v.abort_at == 0);
    drain_done = (v.drain_at == 0);
    push_run(v.exp_ones, v.first_gap);
    pulse(5);
    wait_ones(v.name, 1);
    check($sformatf("%s_busy_fill", v.name), int'(bus.busy), 1);
    check($sformatf("%s_state_fill", v.name), int'(bus.state), int'(FILL));
    c = 0;
    while (!(abort_done && drain_done) && c < 800) begin
      step_cycle();
      c++;
      if (!abort_done && btn_left == 0 && n_ones >= v.abort_at - LEAD) begin
        pulse(5);
        abort_done = 1'b1;
      end
      if (!drain_done && btn_left == 0 && n_zeros >= v.drain_at) begin
        pulse(5);
        drain_done = 1'b1;
      end
    end
    finish_run(v.name, v.exp_ones, v.exp_zeros);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish within 400us");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{"full",        0, 0, 10, 10, 12};
    vecs[1] = '{"abort4",      4, 0,  4, 10,  0};
    vecs[2] = '{"abort3",      3, 0,  3, 10,  0};
    vecs[3] = '{"abort_hold", 10, 0, 10, 10,  0};
    vecs[4] = '{"drain_press", 0, 3, 10, 10, 12};
    vecs[5] = '{"abort7_dp",   7, 5,  7, 10,  0};

    bus.button = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clkin);
    #1;
    check("rst_shift_en", int'(bus.shift_en), 0);
    check("rst_ser_in", int'(bus.ser_in), 0);
    check("rst_state", int'(bus.state), int'(IDLE));
    check("rst_busy", int'(bus.busy), 0);
    check("rst_fill", int'(bus.fill_level), 0);
    rst_n = 1'b1;
    repeat (10) step_cycle();
    check("idle_state", int'(bus.state), int'(IDLE));

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      repeat (6) step_cycle();
    end

    // press landing exactly on a FILL tick: abort wins, no strobe that cycle
    n_ones = 0;
    n_zeros = 0;
    push_run(3 + LEAD, 2 * TICK_DIV);
    pulse(5);
    wait_ones("coincident", 3);
    repeat (RAISE_DLY) step_cycle();
    pulse(5);
    repeat (PRESS_LAT + 1) step_cycle();
    check("coincident_shift_en", int'(bus.shift_en), 0);
    check("coincident_state", int'(bus.state), int'(DRAIN));
    finish_run("coincident", 3 + LEAD, 10);
    repeat (6) step_cycle();

    // asynchronous reset during HOLD, button held high through release
    n_ones = 0;
    n_zeros = 0;
    push_run(10, 12);
    pulse(5);
    wait_ones("rst_hold", 10);
    repeat (3) step_cycle();
    check("rst_hold_state", int'(bus.state), int'(HOLD));
    check("rst_hold_fill", int'(bus.fill_level), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_shift_en", int'(bus.shift_en), 0);
    check("arst_ser_in", int'(bus.ser_in), 0);
    check("arst_state", int'(bus.state), int'(IDLE));
    check("arst_busy", int'(bus.busy), 0);
    check("arst_fill", int'(bus.fill_level), 0);
    exp_q.delete();
    btn_left = 0;
    bus.button = 1'b1;
    repeat (3) step_cycle();
    rst_n = 1'b1;
    repeat (30) step_cycle();
    check("held_btn_state", int'(bus.state), int'(IDLE));
    check("held_btn_busy", int'(bus.busy), 0);
    bus.button = 1'b0;
    repeat (12) step_cycle();
    check("release_btn_state", int'(bus.state), int'(IDLE));

    // two-cycle glitch on the button
    n_ones = 0;
    n_zeros = 0;
`ifdef SHIFT_SEQ_DEBOUNCE_EN
    pulse(2);
    repeat (12) step_cycle();
    check("glitch_state", int'(bus.state), int'(IDLE));
    check("glitch_busy", int'(bus.busy), 0);
    repeat (20) step_cycle();
    check("glitch_ones", n_ones, 0);
`else
    push_run(10, 12);
    pulse(2);
    repeat (12) step_cycle();
    check("glitch_state", int'(bus.state), int'(FILL));
    finish_run("glitch", 10, 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 10: length of the controlled shift register.
REQ-002 Parameter TICK_DIV, default 5000000: clkin cycles per shift tick.
REQ-003 Parameter HOLD_TICKS, default 4: ticks spent full before draining.
REQ-004 Parameter DB_CYCLES, default 250000: cycles the synchronised button must stay stable to be accepted (DEBOUNCE_EN only).
REQ-005 clkin  in  1: single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-007 button  in  1: raw asynchronous start/abort request, active-high.
REQ-008 shift_en  out  1: one-cycle strobe; downstream register shifts left once per strobe.
REQ-009 ser_in  out  1: bit shifted into bit 0, valid whenever shift_en=1.
REQ-010 state  out  2: current FSM state encoding.
REQ-011 busy  out  1: high in any state other than IDLE.
REQ-012 fill_level  out  $clog2(WIDTH+1): count of ones currently held downstream, range 0..WIDTH.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 free-running from reset; internal tick is high for exactly the one cycle where count = TICK_DIV-1, then the count wraps to 0.
REQ-014 button SHALL pass through a 2-flop synchroniser; press = rising edge of the conditioned level, one-cycle pulse.
REQ-015 States: IDLE=0, FILL=1, HOLD=2, DRAIN=3.
REQ-016 IDLE: shift_en=0; press -> FILL, step counter cleared.
REQ-017 FILL: each tick -> shift_en=1, ser_in=1, fill_level+1; after the WIDTH-th such shift -> HOLD, counter cleared.
REQ-018 HOLD: no shifts; after HOLD_TICKS ticks -> DRAIN, counter cleared.
REQ-019 DRAIN: each tick -> shift_en=1, ser_in=0, fill_level-1 (saturating at 0); after WIDTH shifts -> IDLE.
REQ-020 Press in FILL or HOLD SHALL abort -> DRAIN next cycle, counter cleared; DRAIN always issues exactly WIDTH shifts.
REQ-021 Press in DRAIN SHALL be ignored.
REQ-022 Press and tick in the same cycle: press wins; no shift_en that cycle.
REQ-023 shift_en and ser_in SHALL be registered outputs: strobe appears the cycle after the tick.
REQ-024 fill_level SHALL never exceed WIDTH nor wrap below 0.

Reset
REQ-025 While rst_n=0: state=IDLE, shift_en=0, ser_in=0, busy=0, fill_level=0, prescaler=0, step counter=0, synchroniser and debouncer flops=0.
REQ-026 Reset asserted mid-FILL/HOLD/DRAIN SHALL abandon the sequence; no strobe in the cycle after release.
REQ-027 A button held high through reset release SHALL NOT register a press until it falls and rises again.

Configuration
REQ-028 Macro SHIFT_SEQ_DEBOUNCE_EN defined: synchronised button accepted only after DB_CYCLES consecutive equal samples; press = rising edge of accepted level.
REQ-029 Macro undefined: press = rising edge of the synchroniser output directly; DB_CYCLES unused.

Structure
REQ-030 Shared package shift_seq_pkg SHALL hold the state enum typedef (IDLE/FILL/HOLD/DRAIN) and the default parameter constants.
REQ-031 Button conditioning (synchroniser plus optional debounce plus edge detect) SHALL be one sub-module, btn_cond; prescaler and FSM stay in shift_seq_ctrl.

Verification (TICK_DIV=4, WIDTH=10, HOLD_TICKS=2, DB_CYCLES=3)
REQ-032 Single press from IDLE -> 10 strobes with ser_in=1 spaced 4 cycles apart, fill_level 0->10, HOLD for 2 ticks, 10 strobes with ser_in=0, fill_level 10->0, busy falls on entry to IDLE.
REQ-033 Press after 4 FILL strobes -> DRAIN next cycle; exactly 10 zero strobes; fill_level 4->0 then holds 0.
REQ-034 Press coincident with tick in FILL -> no strobe that cycle; state=DRAIN.
REQ-035 rst_n pulled low in HOLD -> all outputs 0 asynchronously; after release, button held high -> stays IDLE.
REQ-036 With SHIFT_SEQ_DEBOUNCE_EN: 2-cycle glitch on button -> no press; 5-cycle high pulse -> FILL starts; without macro, the 2-cycle glitch starts FILL.
REQ-037 Press during DRAIN -> ignored; strobe count and timing unchanged.
